// File: rtl/apb_master.sv
// APB3 initiator: turns a valid/ready command into SETUP/ACCESS transfers.
// A wait-state timeout aborts transfers whose completer never raises pready.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] wait_cnt;
  logic          accept;
  logic          done;
  logic          expire;

  // Ready is withheld during reset and in the response cycle.
  assign cmd_ready = (state == IDLE) && !rsp_valid && !preset;
  assign accept    = cmd_valid && cmd_ready;
  assign done      = (state == ACCESS) && pready;
  assign expire    = (state == ACCESS) && !pready && (wait_cnt == CNT_MAX);
  assign psel      = (state != IDLE);
  assign penable   = (state == ACCESS);

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (done || expire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Wait-state counter: cleared in SETUP, counts ACCESS cycles without pready.
  always_ff @(posedge pclk) begin
    if (preset)
      wait_cnt <= '0;
    else if (state == SETUP)
      wait_cnt <= '0;
    else if ((state == ACCESS) && !pready && !expire)
      wait_cnt <= wait_cnt + CW'(1);
  end

  // Request registers, loaded on the accepting edge and held otherwise.
  always_ff @(posedge pclk) begin
    if (preset) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if (accept) begin
      pwrite <= cmd_write;
      paddr  <= cmd_addr;
      pwdata <= cmd_wdata;
    end
  end

  // Response registers: one-cycle valid pulse, payload held between pulses.
  always_ff @(posedge pclk) begin
    if (preset) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= done || expire;
      if (done) begin
        rsp_rdata   <= pwrite ? '0 : prdata;
        rsp_slverr  <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (expire) begin
        rsp_rdata   <= '0;
        rsp_slverr  <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master.
// Scoreboard of expected responses, one task per scenario.
module tb_apb_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          preset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  apb_master #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT(TO)
  ) dut (
    .pclk(pclk),
    .preset(preset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          slverr;
    logic          tmo;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    int            lat;
    int            psel_n;
    int            pen_n;
    bit            stable;
    bit            got;
    bit            rdy_at_rsp;
    logic [DW-1:0] rdata;
    logic          slverr;
    logic          tmo;
  } obs_t;

  // Issue one command and act as the completer.
  // waits < 0 means pready never rises.
  task automatic do_xfer(input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int waits,
                         input logic [DW-1:0] rd, input logic se,
                         output obs_t o);
    int g;
    int wc;
    o.lat = 0; o.psel_n = 0; o.pen_n = 0; o.stable = 1'b1;
    o.got = 1'b0; o.rdy_at_rsp = 1'b1;
    o.rdata = '0; o.slverr = 1'b0; o.tmo = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    g = 0;
    while (cmd_ready !== 1'b1 && g < 50) begin
      @(posedge pclk); #1; g++;
    end
    @(posedge pclk); #1;
    cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = ~a; cmd_wdata = ~d;
    wc = 0;
    for (int k = 1; k <= 100; k++) begin
      if (psel) begin
        o.psel_n++;
        if (paddr !== a || pwdata !== d || pwrite !== w) o.stable = 1'b0;
      end
      if (penable) o.pen_n++;
      if (rsp_valid) begin
        o.got = 1'b1; o.lat = k; o.rdata = rsp_rdata;
        o.slverr = rsp_slverr; o.tmo = rsp_timeout;
        o.rdy_at_rsp = cmd_ready;
        break;
      end
      if (psel && penable) begin
        if (waits >= 0 && wc == waits) begin
          pready = 1'b1; prdata = rd; pslverr = se;
        end else begin
          pready = 1'b0; prdata = $urandom; pslverr = 1'b1;
        end
        wc++;
      end else begin
        pready = 1'b0; prdata = $urandom; pslverr = 1'b1;
      end
      @(posedge pclk); #1;
    end
    pready = 1'b0; pslverr = 1'b0;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    total++;
    if (psel !== 1'b0 || penable !== 1'b0 || pwrite !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl psel=%b penable=%b pwrite=%b want 000",
               psel, penable, pwrite);
    end
    total++;
    if (paddr !== '0 || pwdata !== '0) begin
      bad++;
      $display("FAIL reset_req paddr=%h pwdata=%h want 0", paddr, pwdata);
    end
    total++;
    if (rsp_valid !== 1'b0 || rsp_slverr !== 1'b0 ||
        rsp_timeout !== 1'b0 || rsp_rdata !== '0) begin
      bad++;
      $display("FAIL reset_rsp v=%b e=%b t=%b d=%h want all 0",
               rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata);
    end
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_held got=%b want 0", cmd_ready);
    end
    preset = 1'b0;
    @(posedge pclk); #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_release got=%b want 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    obs_t o;
    exp_t e;
    sb.push_back('{rdata: '0, slverr: 1'b0, tmo: 1'b0});
    do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h0BAD_F00D, 1'b0, o);
    total++;
    if (!o.got || o.lat != 3) begin
      bad++;
      $display("FAIL wr_latency got=%0d (rsp=%b) want 3", o.lat, o.got);
    end
    total++;
    if (o.psel_n != 2 || o.pen_n != 1) begin
      bad++;
      $display("FAIL wr_phases psel=%0d penable=%0d want 2 1",
               o.psel_n, o.pen_n);
    end
    total++;
    if (!o.stable) begin
      bad++;
      $display("FAIL wr_stable req fields changed, want 10/1/DEADBEEF");
    end
    total++;
    if (o.rdy_at_rsp !== 1'b0) begin
      bad++;
      $display("FAIL wr_ready_at_rsp got=%b want 0", o.rdy_at_rsp);
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL wr_sb empty scoreboard got=0 want 1");
    end else begin
      e = sb.pop_front();
      if (o.rdata !== e.rdata || o.slverr !== e.slverr || o.tmo !== e.tmo) begin
        bad++;
        $display("FAIL wr_rsp got=%h/%b/%b want %h/%b/%b",
                 o.rdata, o.slverr, o.tmo, e.rdata, e.slverr, e.tmo);
      end
    end
  endtask

  task automatic test_read_wait();
    obs_t o;
    exp_t e;
    sb.push_back('{rdata: 32'hDEADBEEF, slverr: 1'b0, tmo: 1'b0});
    do_xfer(1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, o);
    total++;
    if (!o.got || o.lat != 6) begin
      bad++;
      $display("FAIL rd_latency got=%0d (rsp=%b) want 6", o.lat, o.got);
    end
    total++;
    if (o.pen_n != 4 || !o.stable) begin
      bad++;
      $display("FAIL rd_access cycles=%0d stable=%b want 4 1",
               o.pen_n, o.stable);
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL rd_sb empty scoreboard got=0 want 1");
    end else begin
      e = sb.pop_front();
      if (o.rdata !== e.rdata || o.slverr !== e.slverr || o.tmo !== e.tmo) begin
        bad++;
        $display("FAIL rd_rsp got=%h/%b/%b want %h/%b/%b",
                 o.rdata, o.slverr, o.tmo, e.rdata, e.slverr, e.tmo);
      end
    end
  endtask

  task automatic test_slverr();
    obs_t o;
    exp_t e;
    sb.push_back('{rdata: 32'h1234_5678, slverr: 1'b1, tmo: 1'b0});
    do_xfer(1'b0, 32'h24, 32'h0, 1, 32'h1234_5678, 1'b1, o);
    total++;
    if (!o.got || o.lat != 4) begin
      bad++;
      $display("FAIL err_latency got=%0d (rsp=%b) want 4", o.lat, o.got);
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL err_sb empty scoreboard got=0 want 1");
    end else begin
      e = sb.pop_front();
      if (o.rdata !== e.rdata || o.slverr !== e.slverr || o.tmo !== e.tmo) begin
        bad++;
        $display("FAIL err_rsp got=%h/%b/%b want %h/%b/%b",
                 o.rdata, o.slverr, o.tmo, e.rdata, e.slverr, e.tmo);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    exp_t e;
    sb.push_back('{rdata: '0, slverr: 1'b1, tmo: 1'b1});
    do_xfer(1'b0, 32'h30, 32'h0, -1, 32'hFFFF_FFFF, 1'b0, o);
    total++;
    if (!o.got || o.lat != TO + 3) begin
      bad++;
      $display("FAIL tmo_latency got=%0d (rsp=%b) want %0d",
               o.lat, o.got, TO + 3);
    end
    total++;
    if (o.pen_n != TO + 1 || psel !== 1'b0) begin
      bad++;
      $display("FAIL tmo_access cycles=%0d psel=%b want %0d 0",
               o.pen_n, psel, TO + 1);
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL tmo_sb empty scoreboard got=0 want 1");
    end else begin
      e = sb.pop_front();
      if (o.rdata !== e.rdata || o.slverr !== e.slverr || o.tmo !== e.tmo) begin
        bad++;
        $display("FAIL tmo_rsp got=%h/%b/%b want %h/%b/%b",
                 o.rdata, o.slverr, o.tmo, e.rdata, e.slverr, e.tmo);
      end
    end
    @(posedge pclk); #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b1 || rsp_slverr !== 1'b1) begin
      bad++;
      $display("FAIL tmo_hold v=%b t=%b e=%b want 0 1 1",
               rsp_valid, rsp_timeout, rsp_slverr);
    end
    sb.push_back('{rdata: '0, slverr: 1'b0, tmo: 1'b0});
    do_xfer(1'b1, 32'h20, 32'hA5A5_0001, 0, 32'h0, 1'b0, o);
    total++;
    if (!o.got || o.lat != 3) begin
      bad++;
      $display("FAIL tmo_next_latency got=%0d (rsp=%b) want 3", o.lat, o.got);
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL tmo_next_sb empty scoreboard got=0 want 1");
    end else begin
      e = sb.pop_front();
      if (o.rdata !== e.rdata || o.slverr !== e.slverr || o.tmo !== e.tmo) begin
        bad++;
        $display("FAIL tmo_next_rsp got=%h/%b/%b want %h/%b/%b",
                 o.rdata, o.slverr, o.tmo, e.rdata, e.slverr, e.tmo);
      end
    end
  endtask

  task automatic test_reset_mid();
    int g;
    int acc;
    int seen;
    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 32'h44; cmd_wdata = 32'h55AA_55AA;
    g = 0;
    while (cmd_ready !== 1'b1 && g < 50) begin
      @(posedge pclk); #1; g++;
    end
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    pready = 1'b0;
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      if (penable) acc++;
      if (acc == 2) break;
      @(posedge pclk); #1;
    end
    total++;
    if (acc != 2) begin
      bad++;
      $display("FAIL rstmid_reach access=%0d want 2", acc);
    end
    preset = 1'b1;
    @(posedge pclk); #1;
    total++;
    if (psel !== 1'b0 || penable !== 1'b0 || pwrite !== 1'b0 ||
        paddr !== '0 || pwdata !== '0) begin
      bad++;
      $display("FAIL rstmid_apb psel=%b pen=%b pw=%b a=%h d=%h want 0",
               psel, penable, pwrite, paddr, pwdata);
    end
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_rsp v=%b ready=%b want 0 0", rsp_valid, cmd_ready);
    end
    preset = 1'b0;
    seen = 0;
    @(posedge pclk); #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_ready got=%b want 1", cmd_ready);
    end
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid) seen++;
      @(posedge pclk); #1;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL rstmid_no_rsp pulses=%0d want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs[3];
    logic [AW-1:0] setup_a[$];
    int            acc_cyc[$];
    int            idx;
    int            nrsp;
    bit            pend;
    exp_t          e;
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
    for (int i = 0; i < 3; i++)
      sb.push_back('{rdata: '0, slverr: 1'b0, tmo: 1'b0});
    idx = 0; nrsp = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = addrs[0]; cmd_wdata = 32'hC0DE_0000;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (rsp_valid) begin
        nrsp++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL b2b_sb empty scoreboard got=0 want >0");
        end else begin
          e = sb.pop_front();
          if (rsp_rdata !== e.rdata || rsp_slverr !== e.slverr ||
              rsp_timeout !== e.tmo) begin
            bad++;
            $display("FAIL b2b_rsp got=%h/%b/%b want %h/%b/%b",
                     rsp_rdata, rsp_slverr, rsp_timeout,
                     e.rdata, e.slverr, e.tmo);
          end
        end
      end
      if (nrsp == 3) break;
      if (psel && !penable) setup_a.push_back(paddr);
      pready = psel && penable;
      pslverr = 1'b0;
      pend = cmd_valid && cmd_ready;
      if (pend) acc_cyc.push_back(cyc);
      @(posedge pclk); #1;
      if (pend) begin
        idx++;
        if (idx == 3) cmd_valid = 1'b0;
        else begin
          cmd_addr = addrs[idx];
          cmd_wdata = 32'hC0DE_0000 + 32'(idx);
        end
      end
    end
    cmd_valid = 1'b0; pready = 1'b0;
    total++;
    if (nrsp != 3 || acc_cyc.size() != 3) begin
      bad++;
      $display("FAIL b2b_count rsp=%0d acc=%0d want 3 3",
               nrsp, acc_cyc.size());
    end else begin
      total++;
      if (acc_cyc[1] - acc_cyc[0] != 4 || acc_cyc[2] - acc_cyc[1] != 4) begin
        bad++;
        $display("FAIL b2b_spacing got=%0d,%0d want 4,4",
                 acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
      end
    end
    total++;
    if (setup_a.size() != 3) begin
      bad++;
      $display("FAIL b2b_setups got=%0d want 3", setup_a.size());
    end else if (setup_a[0] !== 32'h0 || setup_a[1] !== 32'h4 ||
                 setup_a[2] !== 32'h8) begin
      bad++;
      $display("FAIL b2b_paddr got=%h,%h,%h want 0,4,8",
               setup_a[0], setup_a[1], setup_a[2]);
    end
  endtask

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
